// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the writable program instruction memory.
// Optional parity protection is built when INST_PARITY_EN is defined.
package inst_mem_pkg;

  localparam int DEF_INST_W = 10;
  localparam int DEF_ADDR_W = 8;

  // Opcode 0000 is halt, so an all-zero word is a safe fill for unloaded fetches.
  localparam int HALT_WORD = 0;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  // Even parity over a zero-extended word; zero padding does not change the result.
  function automatic logic even_parity(input logic [63:0] i_data);
    return ^i_data;
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Single-write / single-read synchronous RAM holding the program words.
// Contents are never reset; the read port registers its output and holds it
// until the next read.
module inst_mem_array #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Write port and registered read port; reads and writes never target the
  // same word in the same cycle because fetches are blocked while loading.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/prog_inst_mem.sv
// Writable instruction memory: word-serial program download, then registered
// one-cycle-latency fetch. Optional feature macro: INST_PARITY_EN adds an
// even-parity bit per stored word and a ParityErr output.
//
//   state | meaning
//   IDLE  | serving fetches, waiting for LoadStart
//   LOAD  | accepting download beats, fetches refused
module prog_inst_mem
  import inst_mem_pkg::*;
#(
  parameter int                INST_W    = DEF_INST_W,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DEPTH     = 256,
  parameter logic [INST_W-1:0] FILL_WORD = INST_W'(HALT_WORD)
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              FetchReq,
  input  logic [ADDR_W-1:0] FetchAddr,
  output logic [INST_W-1:0] InstOut,
  output logic              InstValid,
  output logic              FetchBusy,
  input  logic              LoadStart,
  input  logic [ADDR_W-1:0] LoadBase,
  input  logic              LoadValid,
  input  logic [INST_W-1:0] LoadData,
  input  logic              LoadLast,
  output logic              LoadReady,
  output logic              Loaded
`ifdef INST_PARITY_EN
  ,
  output logic              ParityErr
`endif
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef INST_PARITY_EN
  localparam int MEM_W = INST_W + 1;
`else
  localparam int MEM_W = INST_W;
`endif
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_loaded;
  logic              r_inst_valid;
  logic              r_sel_ram;

  logic              w_beat;
  logic              w_load_done;
  logic              w_fetch_ok;
  logic              w_fetch_hit;
  logic              w_wr_en;
  logic [MEM_W-1:0]  w_wr_data;
  logic [MEM_W-1:0]  w_rd_data;
  logic              w_use_ram;

  assign w_beat      = (r_state == LOAD) & LoadValid;
  // A restart in the same cycle as the last beat keeps the download open.
  assign w_load_done = w_beat & LoadLast & ~LoadStart;
  assign w_fetch_ok  = FetchReq & (r_state == IDLE) & ~LoadStart;
  assign w_fetch_hit = w_fetch_ok & r_loaded & ({1'b0, FetchAddr} < DEPTH_C);
  assign w_wr_en     = w_beat & ({1'b0, r_ptr} < DEPTH_C);

`ifdef INST_PARITY_EN
  logic w_par_bad;
  assign w_wr_data = {even_parity(64'(LoadData)), LoadData};
  // Stored word plus its parity bit must XOR to zero.
  assign w_par_bad = r_sel_ram & even_parity(64'(w_rd_data));
  assign w_use_ram = r_sel_ram & ~w_par_bad;
  assign ParityErr = r_inst_valid & w_par_bad;
`else
  assign w_wr_data = LoadData;
  assign w_use_ram = r_sel_ram;
`endif

  inst_mem_array #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH),
    .AW    (MEM_AW)
  ) u_array (
    .i_clk     (Clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_ptr[MEM_AW-1:0]),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_fetch_hit),
    .i_rd_addr (FetchAddr[MEM_AW-1:0]),
    .o_rd_data (w_rd_data)
  );

  // Next-state logic; LoadStart always (re)opens a download.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (LoadStart) w_state_nxt = LOAD;
      LOAD: begin
        if (LoadStart)        w_state_nxt = LOAD;
        else if (w_load_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Load pointer: reload from LoadBase on start, step on every accepted beat.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN)        r_ptr <= '0;
    else if (LoadStart) r_ptr <= LoadBase;
    else if (w_beat)    r_ptr <= r_ptr + 1'b1;
  end

  // Sticky flag: a download has finished since reset.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN)          r_loaded <= 1'b0;
    else if (w_load_done) r_loaded <= 1'b1;
  end

  // Fetch response bookkeeping; the output select only moves on an accepted fetch
  // so InstOut holds between fetches.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_inst_valid <= 1'b0;
      r_sel_ram    <= 1'b0;
    end else begin
      r_inst_valid <= w_fetch_ok;
      if (w_fetch_ok) r_sel_ram <= w_fetch_hit;
    end
  end

  assign InstOut   = w_use_ram ? w_rd_data[INST_W-1:0] : FILL_WORD;
  assign InstValid = r_inst_valid;
  assign LoadReady = (r_state == LOAD);
  assign FetchBusy = (r_state == LOAD);
  assign Loaded    = r_loaded;

endmodule

// File: tb/tb_prog_inst_mem.sv
module tb_prog_inst_mem;

  localparam int IW = 10;
  localparam int AW = 8;
  localparam logic [IW-1:0] FILL = '0;

  logic          Clk = 1'b0;
  logic          ResetN = 1'b1;
  logic          FetchReq = 1'b0;
  logic [AW-1:0] FetchAddr = '0;
  logic          LoadStart = 1'b0;
  logic [AW-1:0] LoadBase = '0;
  logic          LoadValid = 1'b0;
  logic [IW-1:0] LoadData = '0;
  logic          LoadLast = 1'b0;

  logic [IW-1:0] inst_a, inst_b;
  logic          valid_a, valid_b, busy_a, busy_b, ready_a, ready_b, loaded_a, loaded_b;
`ifdef INST_PARITY_EN
  logic          perr_a, perr_b;
`endif

  prog_inst_mem #(.INST_W(IW), .ADDR_W(AW), .DEPTH(256)) u_dut_a (
    .Clk(Clk), .ResetN(ResetN), .FetchReq(FetchReq), .FetchAddr(FetchAddr),
    .InstOut(inst_a), .InstValid(valid_a), .FetchBusy(busy_a),
    .LoadStart(LoadStart), .LoadBase(LoadBase), .LoadValid(LoadValid),
    .LoadData(LoadData), .LoadLast(LoadLast), .LoadReady(ready_a), .Loaded(loaded_a)
`ifdef INST_PARITY_EN
    , .ParityErr(perr_a)
`endif
  );

  prog_inst_mem #(.INST_W(IW), .ADDR_W(AW), .DEPTH(32)) u_dut_b (
    .Clk(Clk), .ResetN(ResetN), .FetchReq(FetchReq), .FetchAddr(FetchAddr),
    .InstOut(inst_b), .InstValid(valid_b), .FetchBusy(busy_b),
    .LoadStart(LoadStart), .LoadBase(LoadBase), .LoadValid(LoadValid),
    .LoadData(LoadData), .LoadLast(LoadLast), .LoadReady(ready_b), .Loaded(loaded_b)
`ifdef INST_PARITY_EN
    , .ParityErr(perr_b)
`endif
  );

  always #5 Clk = ~Clk;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic          req;
    logic [AW-1:0] addr;
    logic          exp_valid;
    logic [IW-1:0] exp_a;
    logic [IW-1:0] exp_b;
  } vec_t;

  vec_t          vecs[8];
  logic [IW-1:0] prog[40];
  logic [IW-1:0] ld_buf[64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    FetchReq  = 1'b1;
    FetchAddr = a;
    step();
    FetchReq  = 1'b0;
  endtask

  task automatic load(input logic [AW-1:0] base, input int n, input bit do_last);
    LoadStart = 1'b1;
    LoadBase  = base;
    step();
    LoadStart = 1'b0;
    for (int i = 0; i < n; i++) begin
      LoadValid = 1'b1;
      LoadData  = ld_buf[i];
      LoadLast  = do_last && (i == n - 1);
      step();
    end
    LoadValid = 1'b0;
    LoadLast  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 40; i++) prog[i] = 10'((i * 53 + 7) % 1024);
    prog[0]  = 10'b0100101001;
    prog[39] = 10'b0000100101;

    vecs[0] = '{1'b1, 8'd0,  1'b1, prog[0],  prog[0]};
    vecs[1] = '{1'b1, 8'd1,  1'b1, prog[1],  prog[1]};
    vecs[2] = '{1'b1, 8'd20, 1'b1, prog[20], prog[20]};
    vecs[3] = '{1'b0, 8'd20, 1'b0, prog[20], prog[20]};
    vecs[4] = '{1'b1, 8'd38, 1'b1, prog[38], FILL};
    vecs[5] = '{1'b1, 8'd31, 1'b1, prog[31], prog[31]};
    vecs[6] = '{1'b1, 8'd32, 1'b1, prog[32], FILL};
    vecs[7] = '{1'b0, 8'd0,  1'b0, prog[32], FILL};

    // reset
    #2 ResetN = 1'b0;
    #1;
    chk("rst_inst",   inst_a,   FILL);
    chk("rst_valid",  valid_a,  0);
    chk("rst_busy",   busy_a,   0);
    chk("rst_ready",  ready_a,  0);
    chk("rst_loaded", loaded_a, 0);
    step();
    step();
    ResetN = 1'b1;
    step();

    // fetch before any download returns fill
    fetch(8'd5);
    chk("unloaded_valid", valid_a, 1);
    chk("unloaded_inst",  inst_a,  FILL);
    step();
    chk("idle_valid_drop", valid_a, 0);

    // LoadStart wins over a coincident fetch
    FetchReq = 1'b1; FetchAddr = 8'd5; LoadStart = 1'b1; LoadBase = 8'd0;
    step();
    LoadStart = 1'b0;
    chk("coinc_valid", valid_a, 0);
    chk("coinc_busy",  busy_a,  1);
    chk("coinc_ready", ready_a, 1);
    step();
    chk("load_fetch_busy",  busy_a,  1);
    chk("load_fetch_valid", valid_a, 0);
    FetchReq = 1'b0;

    // full 40-word program (restart inside LOAD)
    for (int i = 0; i < 40; i++) ld_buf[i] = prog[i];
    load(8'd0, 40, 1'b1);
    chk("loaded_a",   loaded_a, 1);
    chk("loaded_b",   loaded_b, 1);
    chk("ready_done", ready_a,  0);
    chk("busy_done",  busy_a,   0);

    // first IDLE cycle after the last beat sees the new data
    fetch(8'd39);
    chk("f39_valid", valid_a, 1);
    chk("f39_inst",  inst_a,  prog[39]);
    chk("f39_inst_b", inst_b, FILL);

    for (int i = 0; i < 8; i++) begin
      FetchReq  = vecs[i].req;
      FetchAddr = vecs[i].addr;
      step();
      FetchReq = 1'b0;
      chk($sformatf("vec%0d_valid", i),  valid_a, vecs[i].exp_valid);
      chk($sformatf("vec%0d_inst_a", i), inst_a,  vecs[i].exp_a);
      chk($sformatf("vec%0d_inst_b", i), inst_b,  vecs[i].exp_b);
    end

    // pointer wrap 255 -> 0
    ld_buf[0] = 10'h3A1; ld_buf[1] = 10'h2B2; ld_buf[2] = 10'h1C3;
    load(8'd254, 3, 1'b1);
    fetch(8'd0);
    chk("wrap0_a", inst_a, 10'h1C3);
    chk("wrap0_b", inst_b, 10'h1C3);
    fetch(8'd255);
    chk("wrap255_a", inst_a, 10'h2B2);

    // DEPTH=32 instance drops beats past the end
    ld_buf[0] = 10'h155; ld_buf[1] = 10'h2AA; ld_buf[2] = 10'h0F0; ld_buf[3] = 10'h30F;
    load(8'd30, 4, 1'b1);
    fetch(8'd31);
    chk("d32_f31", inst_b, 10'h2AA);
    chk("d256_f31", inst_a, 10'h2AA);
    fetch(8'd30);
    chk("d32_f30", inst_b, 10'h155);
    fetch(8'd40);
    chk("d32_f40", inst_b, FILL);
    chk("d32_f40_valid", valid_b, 1);
    fetch(8'd33);
    chk("d256_f33", inst_a, 10'h30F);

    // reset in the middle of a download
    ld_buf[0] = 10'h011; ld_buf[1] = 10'h022; ld_buf[2] = 10'h033;
    ld_buf[3] = 10'h044; ld_buf[4] = 10'h055;
    load(8'd0, 3, 1'b0);
    chk("mid_busy", busy_a, 1);
    ResetN = 1'b0;
    #1;
    chk("mid_rst_busy",   busy_a,   0);
    chk("mid_rst_loaded", loaded_a, 0);
    step();
    ResetN = 1'b1;
    step();
    fetch(8'd0);
    chk("mid_rst_fetch_valid", valid_a, 1);
    chk("mid_rst_fetch_inst",  inst_a,  FILL);
    load(8'd0, 5, 1'b1);
    chk("reload_loaded", loaded_a, 1);
    fetch(8'd0);
    chk("reload_f0", inst_a, 10'h011);
    fetch(8'd4);
    chk("reload_f4", inst_a, 10'h055);

`ifdef INST_PARITY_EN
    begin
      logic [IW:0] tmp;
      tmp = u_dut_a.u_array.r_mem[7];
      u_dut_a.u_array.r_mem[7] = tmp ^ 11'd1;
    end
    fetch(8'd7);
    chk("par7_err",  perr_a, 1);
    chk("par7_inst", inst_a, FILL);
    fetch(8'd8);
    chk("par8_err",  perr_a, 0);
    chk("par8_inst", inst_a, prog[8]);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prog_inst_mem.md
Name: prog_inst_mem

Overview:
Parametrised, writable instruction memory that replaces the fixed case-table instruction ROM. It is downloaded at run time through a word-serial load port and then serves the fetch stage with a registered, one-cycle-latency read. It sits between the PC/fetch logic and the datapath decoder. Default widths keep the current 10-bit instruction, 8-bit address format.

Parameters:
INST_W, 10, instruction word width in bits
ADDR_W, 8, fetch/load address width in bits
DEPTH, 256, number of implemented words; must be <= 2**ADDR_W
FILL_WORD, 0, word returned for unloaded or out-of-range fetches (opcode 0000 = halt)

Ports:
Clk  in  1  system clock, rising edge
ResetN  in  1  asynchronous active-low reset
FetchReq  in  1  fetch request, sampled each cycle
FetchAddr  in  ADDR_W  fetch address, sampled with FetchReq
InstOut  out  INST_W  registered instruction word
InstValid  out  1  InstOut holds the result of the previous cycle's accepted FetchReq
FetchBusy  out  1  high while a load is in progress; fetches are refused
LoadStart  in  1  one-cycle pulse that begins a program download
LoadBase  in  ADDR_W  first address written, sampled on LoadStart
LoadValid  in  1  LoadData is valid this cycle
LoadData  in  INST_W  instruction word to write
LoadLast  in  1  qualifies the final LoadValid beat
LoadReady  out  1  block accepts a load beat this cycle
Loaded  out  1  at least one download has completed since reset

Behaviour:
- Reset (ResetN low, asynchronous): state IDLE, InstOut=FILL_WORD, InstValid=0, FetchBusy=0, LoadReady=0, Loaded=0, load pointer=0. Array contents are not cleared.
- State machine states: IDLE, LOAD.
  - IDLE -> LOAD on LoadStart. Latch the pointer from LoadBase.
  - LOAD -> IDLE on an accepted beat with LoadLast=1. Set Loaded=1 on that edge.
- LoadStart in LOAD restarts the download: pointer reloads from LoadBase and the state stays LOAD.
- LoadReady=1 exactly when state is LOAD. FetchBusy mirrors LoadReady.
- Accepted beat (LoadReady & LoadValid):
  - If pointer < DEPTH, write LoadData at the pointer.
  - Beats with pointer >= DEPTH are accepted and dropped.
  - Pointer increments modulo 2**ADDR_W, so it wraps 255 -> 0 at default widths.
- Fetch is accepted when FetchReq=1 and state is IDLE. The same edge registers InstOut and sets InstValid=1 for the next cycle (latency 1).
  - If FetchAddr >= DEPTH, or Loaded=0, InstOut=FILL_WORD.
  - With no accepted fetch, InstValid=0 and InstOut holds its last value.
- LoadStart and FetchReq in the same IDLE cycle: the load wins, the fetch is refused and InstValid=0 next cycle.
- Fetch from an address while the download is still writing it is impossible, because fetches are blocked during LOAD.
- A fetch in the first IDLE cycle after LoadLast returns the newly written data (write-before-read ordering across cycles).
- ResetN asserted mid-download: return to IDLE and Loaded=0. Partially written words remain in the array but are masked by Loaded=0.

Optional Feature:
Macro INST_PARITY_EN.
- Defined:
  - Each array word stores INST_W+1 bits, including an even-parity bit computed on write.
  - Fetch recomputes parity. Output ParityErr (1 bit, registered, timed with InstValid) is set on a mismatch.
  - On a mismatch, InstOut is forced to FILL_WORD.
  - ParityErr resets to 0.
- Undefined: the ParityErr port and the parity storage are absent; array width is INST_W.

Decomposition:
- Package inst_mem_pkg holds:
  - the state enum (IDLE, LOAD);
  - the HALT_WORD constant (FILL_WORD default);
  - default INST_W/ADDR_W constants;
  - the parity helper function.
- One sub-module, inst_mem_array: a simple single-write/single-read synchronous RAM (DEPTH x INST_W, +1 under INST_PARITY_EN). No reset on its contents.

Test Plan:
- Reset, then FetchReq with FetchAddr=5 -> InstValid=1 next cycle, InstOut=0 (Loaded=0).
- LoadStart with LoadBase=0, then 40 beats (the current even-count program, last beat with LoadLast) -> Loaded=1. Fetch addr 0 returns 10'b0100101001; fetch addr 39 returns 10'b0000100101, each with 1-cycle latency.
- During LOAD, FetchReq=1 -> FetchBusy=1, InstValid=0. LoadStart coincident with FetchReq in IDLE -> fetch refused.
- With DEPTH=32, load from LoadBase=30 for 4 beats -> addresses 30 and 31 are written, the beats at pointer 32 and 33 are dropped. Fetch 31 returns the second word; fetch 40 returns FILL_WORD.
- Assert ResetN low after 3 of 5 beats -> state IDLE, Loaded=0, fetch returns 0. A new full load then succeeds.
- With INST_PARITY_EN, force a bit flip in the array word at address 7 -> fetch 7 gives ParityErr=1 and InstOut=FILL_WORD; fetch 8 gives ParityErr=0.
